// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, status bit positions and FSM state for alu_seq
//
// Shared definitions for the registered ALU:
//   OP_*      5-bit opcode encodings
//   *_B       bit positions inside the 6-bit Status word {CF,ZF,NF,VF,PF,AF}
//   state_t   sequencer state (IDLE accepts, MUL_BUSY iterates the multiplier)
//   pack_status assembles a Status word from individual flags
package alu_pkg;

    localparam logic [4:0] OP_INC = 5'b00001;
    localparam logic [4:0] OP_DEC = 5'b00011;
    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_ADC = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_SBB = 5'b00111;
    localparam logic [4:0] OP_AND = 5'b01000;
    localparam logic [4:0] OP_OR  = 5'b01001;
    localparam logic [4:0] OP_XOR = 5'b01010;
    localparam logic [4:0] OP_NOT = 5'b01011;
    localparam logic [4:0] OP_CLC = 5'b01100;
    localparam logic [4:0] OP_STC = 5'b01101;
    localparam logic [4:0] OP_SHL = 5'b10000;
    localparam logic [4:0] OP_SHR = 5'b10001;
    localparam logic [4:0] OP_SAL = 5'b10010;
    localparam logic [4:0] OP_SAR = 5'b10011;
    localparam logic [4:0] OP_ROL = 5'b10100;
    localparam logic [4:0] OP_ROR = 5'b10101;
    localparam logic [4:0] OP_RCL = 5'b10110;
    localparam logic [4:0] OP_RCR = 5'b10111;
    localparam logic [4:0] OP_MUL = 5'b11000;

    localparam int CF_B = 5;
    localparam int ZF_B = 4;
    localparam int NF_B = 3;
    localparam int VF_B = 2;
    localparam int PF_B = 1;
    localparam int AF_B = 0;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    function automatic logic [5:0] pack_status(
        input logic cf,
        input logic zf,
        input logic nf,
        input logic vf,
        input logic pf,
        input logic af
    );
        logic [5:0] s;
        s       = '0;
        s[CF_B] = cf;
        s[ZF_B] = zf;
        s[NF_B] = nf;
        s[VF_B] = vf;
        s[PF_B] = pf;
        s[AF_B] = af;
        return s;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle for alu_seq
//
// Groups the operation input stage (in_valid/in_ready, A, B, F) and the held
// result stage (out_valid/out_ready, Result, Result_hi, Status, out_err).
//   master : producer/consumer side (drives operands, takes results)
//   slave  : ALU side
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       F;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Result_hi;
    logic [5:0]       Status;
    logic             out_err;

    modport master (
        output in_valid, A, B, F, out_ready,
        input  in_ready, out_valid, Result, Result_hi, Status, out_err
    );

    modport slave (
        input  in_valid, A, B, F, out_ready,
        output in_ready, out_valid, Result, Result_hi, Status, out_err
    );

endinterface

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add unsigned multiplier
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   start     load A/B and begin (ignored-safe: only pulsed when idle)
//   A, B      unsigned operands, captured on the start edge
//   busy      iteration in progress
//   done      one-cycle pulse, product valid while high
//   product   2*WIDTH-bit result A*B
//
// Classic right-shifting product register: the low half starts as the
// multiplier, each step conditionally adds the multiplicand into the high
// half and shifts the whole {carry,hi,lo} right by one. After WIDTH steps
// the register holds the full product.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] p_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH:0]     sum;

    assign sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mcand_q} : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q     <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                p_q     <= {{WIDTH{1'b0}}, B};
                mcand_q <= A;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
            end else if (busy_q) begin
                p_q   <= {sum, p_q[WIDTH-1:1]};
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = p_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered parametrised ALU with persistent CF and iterative MUL
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   alu_seq_if.slave: in_valid/in_ready/A/B/F operation input,
//         out_valid/out_ready/Result/Result_hi/Status/out_err held result
//
// Single-cycle ops load the output stage on their acceptance edge. MUL hands
// off to alu_mul_iter and the output stage loads on the edge that returns the
// sequencer to IDLE. CF lives in cf_q and is refreshed on every output load,
// which lets ADC/SBB/RCL/RCR chain across operations.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);

    localparam int MSB = WIDTH - 1;

    state_t             state_q, state_d;
    logic               cf_q;
    logic               out_valid_q;
    logic               out_err_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic [5:0]         status_q;

    logic [WIDTH-1:0]   a, b;
    logic               cin;
    logic               in_ready;
    logic               accept;
    logic               is_mul;

    logic               mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH-1:0]   mul_lo, mul_hi;
    logic [5:0]         mul_status;

    logic [WIDTH:0]     wide;
    logic [WIDTH-1:0]   sc_r;
    logic               sc_cf, sc_vf, sc_af, sc_err;
    logic [5:0]         sc_status;

    assign a   = bus.A;
    assign b   = bus.B;
    assign cin = cf_q;

    // A new op is only taken when the output slot is empty or being drained
    // on this same edge, so a loaded result can never be overwritten.
    assign in_ready  = (state_q == IDLE) && !mul_busy && (!out_valid_q || bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign is_mul    = (bus.F == OP_MUL) && MUL_EN;
    assign mul_start = accept && is_mul;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .A       (a),
        .B       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (mul_start) state_d = MUL_BUSY;
            MUL_BUSY: if (mul_done)  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Single-cycle datapath. AF is the carry/borrow into bit 4, recovered as
    // (a ^ operand ^ result)[4]; that identity holds for add and subtract,
    // with or without carry-in.
    always_comb begin
        wide   = '0;
        sc_r   = '0;
        sc_cf  = 1'b0;
        sc_vf  = 1'b0;
        sc_af  = 1'b0;
        sc_err = 1'b0;
        case (bus.F)
            OP_INC: begin
                wide  = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
                sc_r  = wide[MSB:0];
                sc_cf = wide[WIDTH];
                sc_vf = (a == {1'b0, {MSB{1'b1}}});
                sc_af = a[4] ^ sc_r[4];
            end
            OP_DEC: begin
                wide  = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
                sc_r  = wide[MSB:0];
                sc_cf = wide[WIDTH];
                sc_vf = (a == {1'b1, {MSB{1'b0}}});
                sc_af = a[4] ^ sc_r[4];
            end
            OP_ADD, OP_ADC: begin
                wide  = {1'b0, a} + {1'b0, b}
                      + ((bus.F == OP_ADC) ? {{WIDTH{1'b0}}, cin} : '0);
                sc_r  = wide[MSB:0];
                sc_cf = wide[WIDTH];
                sc_vf = (a[MSB] == b[MSB]) && (sc_r[MSB] != a[MSB]);
                sc_af = a[4] ^ b[4] ^ sc_r[4];
            end
            OP_SUB, OP_SBB: begin
                // The W+1-bit difference goes negative exactly when
                // A < B (+cin), so its top bit is the borrow.
                wide  = {1'b0, a} - {1'b0, b}
                      - ((bus.F == OP_SBB) ? {{WIDTH{1'b0}}, cin} : '0);
                sc_r  = wide[MSB:0];
                sc_cf = wide[WIDTH];
                sc_vf = (a[MSB] != b[MSB]) && (sc_r[MSB] != a[MSB]);
                sc_af = a[4] ^ b[4] ^ sc_r[4];
            end
            OP_AND: sc_r = a & b;
            OP_OR:  sc_r = a | b;
            OP_XOR: sc_r = a ^ b;
            OP_NOT: sc_r = ~a;
            OP_CLC: sc_r = a;
            OP_STC: begin
                sc_r  = a;
                sc_cf = 1'b1;
            end
            OP_SHL, OP_SAL: begin
                sc_r  = {a[MSB-1:0], 1'b0};
                sc_cf = a[MSB];
            end
            OP_SHR: begin
                sc_r  = {1'b0, a[MSB:1]};
                sc_cf = a[0];
            end
            OP_SAR: begin
                sc_r  = {a[MSB], a[MSB:1]};
                sc_cf = a[0];
            end
            OP_ROL: begin
                sc_r  = {a[MSB-1:0], a[MSB]};
                sc_cf = a[MSB];
            end
            OP_ROR: begin
                sc_r  = {a[0], a[MSB:1]};
                sc_cf = a[0];
            end
            OP_RCL: begin
                sc_r  = {a[MSB-1:0], cin};
                sc_cf = a[MSB];
            end
            OP_RCR: begin
                sc_r  = {cin, a[MSB:1]};
                sc_cf = a[0];
            end
            // With the multiplier present MUL never takes this path; without
            // it the opcode falls into the illegal result.
            OP_MUL:  sc_err = !MUL_EN;
            default: sc_err = 1'b1;
        endcase
    end

    // Illegal ops leave sc_r/sc_cf/sc_vf/sc_af at zero, which yields the
    // fixed ZF=1, PF=1 status without a special case.
    assign sc_status = pack_status(sc_cf, (sc_r == '0), sc_r[MSB], sc_vf, ~^sc_r, sc_af);

    assign mul_lo     = mul_product[MSB:0];
    assign mul_hi     = mul_product[2*WIDTH-1:WIDTH];
    assign mul_status = pack_status((mul_hi != '0), (mul_lo == '0), mul_lo[MSB],
                                    (mul_hi != '0), ~^mul_lo, 1'b0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            status_q    <= '0;
            out_err_q   <= 1'b0;
            cf_q        <= 1'b0;
        end else if (accept && !is_mul) begin
            out_valid_q <= 1'b1;
            result_q    <= sc_r;
            result_hi_q <= '0;
            status_q    <= sc_status;
            out_err_q   <= sc_err;
            cf_q        <= sc_status[CF_B];
        end else if (mul_done) begin
            out_valid_q <= 1'b1;
            result_q    <= mul_lo;
            result_hi_q <= mul_hi;
            status_q    <= mul_status;
            out_err_q   <= 1'b0;
            cf_q        <= mul_status[CF_B];
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.Result    = result_q;
    assign bus.Result_hi = result_hi_q;
    assign bus.Status    = status_q;
    assign bus.out_err   = out_err_q;

endmodule
